mul_bram_responder: RTL and testbench

- Memory-side responder for the matrix-multiply engine's BRAM interface.
- Serves three independent 64-bit read ports with 1-cycle registered latency, and accepts engine save writes.
- Arbitrates a host load/unload port that preloads matrices and reads results while the engine is idle.
- Built as three replicated single-write banks, so all three reads proceed every cycle without conflict.

---
 rtl/mul_mem_pkg.sv | 23 ++
 rtl/mul_bram_responder_if.sv | 40 ++++
 rtl/mul_bram_bank.sv | 30 +++
 rtl/mul_bram_responder.sv | 176 +++++++++++++++++
 tb/tb_mul_bram_responder.sv | 314 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mul_mem_pkg.sv
// Shared types and address helpers for the matrix-multiply BRAM responder.
// Word indices are computed at a fixed wide width so any ADDR_WIDTH up to 64 fits.
package mul_mem_pkg;

    typedef enum logic [1:0] {
        IDLE,
        HOST,
        ENGINE,
        DRAIN
    } state_t;

    localparam int WORD_BYTES_LOG2 = 3;
    localparam int MAX_ADDR_W      = 64;

    function automatic logic [MAX_ADDR_W-1:0] word_idx(input logic [MAX_ADDR_W-1:0] addr);
        return addr >> WORD_BYTES_LOG2;
    endfunction

    function automatic logic in_range(input logic [MAX_ADDR_W-1:0] idx, input int unsigned depth);
        return idx < MAX_ADDR_W'(depth);
    endfunction

endpackage

// File: rtl/mul_bram_responder_if.sv
// Engine read/save ports and the host load/unload port of the BRAM responder.
// master = engine + host side, slave = the memory responder.
interface mul_bram_responder_if #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 32
) ();
    logic                  engine_busy;
    logic [ADDR_WIDTH-1:0] bram_addr_1;
    logic [ADDR_WIDTH-1:0] bram_addr_2;
    logic [ADDR_WIDTH-1:0] bram_addr_3;
    logic [DATA_WIDTH-1:0] bram_data_1;
    logic [DATA_WIDTH-1:0] bram_data_2;
    logic [DATA_WIDTH-1:0] bram_data_3;
    logic                  save_wen;
    logic [ADDR_WIDTH-1:0] save_addr;
    logic [DATA_WIDTH-1:0] bram_savedata;
    logic                  host_req;
    logic                  host_we;
    logic [ADDR_WIDTH-1:0] host_addr;
    logic [DATA_WIDTH-1:0] host_wdata;
    logic                  host_gnt;
    logic                  host_rvalid;
    logic [DATA_WIDTH-1:0] host_rdata;

    modport master (
        output engine_busy, bram_addr_1, bram_addr_2, bram_addr_3,
        output save_wen, save_addr, bram_savedata,
        output host_req, host_we, host_addr, host_wdata,
        input  bram_data_1, bram_data_2, bram_data_3,
        input  host_gnt, host_rvalid, host_rdata
    );

    modport slave (
        input  engine_busy, bram_addr_1, bram_addr_2, bram_addr_3,
        input  save_wen, save_addr, bram_savedata,
        input  host_req, host_we, host_addr, host_wdata,
        output bram_data_1, bram_data_2, bram_data_3,
        output host_gnt, host_rvalid, host_rdata
    );
endinterface

// File: rtl/mul_bram_bank.sv
// One BRAM bank: single write port, one registered read port.
// A same-cycle write to the word being read is forwarded (write-first).
module mul_bram_bank #(
    parameter int DATA_WIDTH = 64,
    parameter int DEPTH      = 4096,
    parameter int AW         = 12
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [AW-1:0]         waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [AW-1:0]         raddr,
    output logic [DATA_WIDTH-1:0] rdata
);
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DATA_WIDTH-1:0] rdata_reg;

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (we && (waddr == raddr)) begin
            rdata_reg <= wdata;
        end else begin
            rdata_reg <= mem[raddr];
        end
    end

    assign rdata = rdata_reg;
endmodule

// File: rtl/mul_bram_responder.sv
// Memory-side responder for the matrix-multiply engine: three replicated banks,
// engine saves, and an idle-time host port. MUL_BRAM_STATS_EN adds rd_count/wr_conflict.
module mul_bram_responder
    import mul_mem_pkg::*;
#(
    parameter int DATA_WIDTH  = 64,
    parameter int ADDR_WIDTH  = 32,
    parameter int DEPTH_WORDS = 4096
) (
    input  logic                clk,
    input  logic                rst_n,
    mul_bram_responder_if.slave bus,
    output logic [15:0]         save_count,
    output logic                addr_err
`ifdef MUL_BRAM_STATS_EN
    ,
    output logic [31:0]         rd_count,
    output logic                wr_conflict
`endif
);
    localparam int BANK_AW = $clog2(DEPTH_WORDS);

    state_t state_reg, state_next;

    logic                  host_gnt;
    logic                  host_wr_block;
    logic                  eng_phase;
    logic                  engine_start;
    logic                  eng_wr, host_wr, wr_req, wr_ok, wr_en;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [DATA_WIDTH-1:0] wr_data;
    logic [MAX_ADDR_W-1:0] wr_full_idx;
    logic [ADDR_WIDTH-1:0] rd_addr [3];
    logic [2:0]            rd_ok, rd_ok_reg, rd_err;
    logic [DATA_WIDTH-1:0] bank_rdata [3];
    logic [DATA_WIDTH-1:0] bram_data [3];
    logic [15:0]           save_count_reg;
    logic                  addr_err_reg;
    logic                  host_rvalid_reg;

    always_comb begin
        state_next = state_reg;
        host_gnt   = 1'b0;
        unique case (state_reg)
            IDLE: begin
                if (bus.engine_busy) begin
                    state_next = ENGINE;
                end else if (bus.host_req) begin
                    state_next = HOST;
                end
            end
            HOST: begin
                // Engine always pre-empts the host, even mid-request.
                if (bus.engine_busy) begin
                    state_next = ENGINE;
                end else begin
                    host_gnt = bus.host_req & ~host_wr_block;
                    if (!bus.host_req) begin
                        state_next = IDLE;
                    end
                end
            end
            ENGINE: begin
                if (!bus.engine_busy) begin
                    state_next = DRAIN;
                end
            end
            DRAIN:   state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign eng_phase    = (state_reg == ENGINE) || (state_reg == DRAIN);
    assign engine_start = (state_next == ENGINE) && (state_reg != ENGINE);

    // Bank 1 is lent to the host while the engine is idle.
    assign rd_addr[0] = (state_reg == HOST) ? bus.host_addr : bus.bram_addr_1;
    assign rd_addr[1] = bus.bram_addr_2;
    assign rd_addr[2] = bus.bram_addr_3;

    assign eng_wr      = bus.save_wen & eng_phase;
    assign host_wr     = host_gnt & bus.host_we;
    assign wr_req      = eng_wr | host_wr;
    assign wr_addr     = eng_wr ? bus.save_addr : bus.host_addr;
    assign wr_data     = eng_wr ? bus.bram_savedata : bus.host_wdata;
    assign wr_full_idx = word_idx(MAX_ADDR_W'(wr_addr));
    assign wr_ok       = in_range(wr_full_idx, DEPTH_WORDS);
    assign wr_en       = wr_req & wr_ok;

    for (genvar gi = 0; gi < 3; gi++) begin : g_bank
        logic [MAX_ADDR_W-1:0] rd_full_idx;

        assign rd_full_idx = word_idx(MAX_ADDR_W'(rd_addr[gi]));
        assign rd_ok[gi]   = in_range(rd_full_idx, DEPTH_WORDS);

        mul_bram_bank #(
            .DATA_WIDTH (DATA_WIDTH),
            .DEPTH      (DEPTH_WORDS),
            .AW         (BANK_AW)
        ) u_bank (
            .clk   (clk),
            .we    (wr_en),
            .waddr (wr_full_idx[BANK_AW-1:0]),
            .wdata (wr_data),
            .raddr (rd_full_idx[BANK_AW-1:0]),
            .rdata (bank_rdata[gi])
        );

        assign bram_data[gi] = rd_ok_reg[gi] ? bank_rdata[gi] : '0;
    end

    assign rd_err[0]   = ~rd_ok[0] & (eng_phase | (host_gnt & ~bus.host_we));
    assign rd_err[2:1] = ~rd_ok[2:1] & {2{eng_phase}};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg       <= IDLE;
            rd_ok_reg       <= '0;
            host_rvalid_reg <= 1'b0;
            save_count_reg  <= '0;
            addr_err_reg    <= 1'b0;
        end else begin
            state_reg       <= state_next;
            rd_ok_reg       <= rd_ok;
            host_rvalid_reg <= host_gnt & ~bus.host_we;
            if (engine_start) begin
                save_count_reg <= '0;
            end else if (eng_wr && (save_count_reg != 16'hFFFF)) begin
                save_count_reg <= save_count_reg + 16'd1;
            end
            if ((wr_req && !wr_ok) || (|rd_err)) begin
                addr_err_reg <= 1'b1;
            end
        end
    end

`ifdef MUL_BRAM_STATS_EN
    logic [31:0] rd_count_reg;
    logic        wr_conflict_reg;

    // A host write racing an engine save is refused rather than merged.
    assign host_wr_block = bus.save_wen & bus.host_we;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_count_reg    <= '0;
            wr_conflict_reg <= 1'b0;
        end else if (engine_start) begin
            rd_count_reg    <= '0;
            wr_conflict_reg <= 1'b0;
        end else begin
            if (state_reg == ENGINE) begin
                rd_count_reg <= rd_count_reg + 32'd1;
            end
            if (bus.save_wen && bus.host_req && bus.host_we) begin
                wr_conflict_reg <= 1'b1;
            end
        end
    end

    assign rd_count    = rd_count_reg;
    assign wr_conflict = wr_conflict_reg;
`else
    assign host_wr_block = 1'b0;
`endif

    assign bus.bram_data_1 = bram_data[0];
    assign bus.bram_data_2 = bram_data[1];
    assign bus.bram_data_3 = bram_data[2];
    assign bus.host_gnt    = host_gnt;
    assign bus.host_rvalid = host_rvalid_reg;
    assign bus.host_rdata  = host_rvalid_reg ? bram_data[0] : '0;
    assign save_count      = save_count_reg;
    assign addr_err        = addr_err_reg;

endmodule

// File: tb/tb_mul_bram_responder.sv
// Scoreboard bench for mul_bram_responder: stimulus queues expected read data,
// a negedge monitor pops and compares host and engine responses.
module tb_mul_bram_responder;

    localparam logic [63:0] W8  = 64'h0123_4567_89AB_CDEF;
    localparam logic [63:0] W9  = 64'h1111_2222_3333_4444;
    localparam logic [63:0] WAA = 64'h0000_0000_0000_00AA;

    typedef struct packed {
        logic [63:0] d1;
        logic [63:0] d2;
        logic [63:0] d3;
    } eng_exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] save_count;
    logic        addr_err;
`ifdef MUL_BRAM_STATS_EN
    logic [31:0] rd_count;
    logic        wr_conflict;
`endif

    int checks   = 0;
    int failures = 0;

    logic [63:0] host_q [$];
    eng_exp_t    eng_q  [$];
    bit          eng_issue   = 1'b0;
    bit          eng_issue_d = 1'b0;

    mul_bram_responder_if #(.DATA_WIDTH(64), .ADDR_WIDTH(32)) bus ();

    mul_bram_responder #(
        .DATA_WIDTH  (64),
        .ADDR_WIDTH  (32),
        .DEPTH_WORDS (4096)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus),
        .save_count (save_count),
        .addr_err   (addr_err)
`ifdef MUL_BRAM_STATS_EN
        ,
        .rd_count   (rd_count),
        .wr_conflict(wr_conflict)
`endif
    );

    always #5 clk = ~clk;

    function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end else begin
            $display("ok   %s value=%h", name, act);
        end
    endfunction

    // Monitor: engine reads issued on the previous edge, and any host rvalid.
    always @(posedge clk) eng_issue_d <= eng_issue;

    always @(negedge clk) begin
        if (rst_n && eng_issue_d) begin
            if (eng_q.size() == 0) begin
                check("eng_q_underflow", 64'(eng_q.size()), 64'd1);
            end else begin
                eng_exp_t e;
                e = eng_q.pop_front();
                check("eng_data_1", bus.bram_data_1, e.d1);
                check("eng_data_2", bus.bram_data_2, e.d2);
                check("eng_data_3", bus.bram_data_3, e.d3);
            end
        end
        if (bus.host_rvalid) begin
            if (host_q.size() == 0) begin
                check("host_rvalid_unexpected", 64'(bus.host_rvalid), 64'd0);
            end else begin
                check("host_rdata", bus.host_rdata, host_q.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_gnt(string name);
        int n = 0;
        @(negedge clk);
        while (!bus.host_gnt && n < 20) begin
            @(negedge clk);
            n++;
        end
        check(name, 64'(bus.host_gnt), 64'd1);
    endtask

    task automatic host_write(logic [31:0] addr, logic [63:0] data);
        bus.host_req   = 1'b1;
        bus.host_we    = 1'b1;
        bus.host_addr  = addr;
        bus.host_wdata = data;
        wait_gnt("host_wr_gnt");
        tick();
        bus.host_req = 1'b0;
        bus.host_we  = 1'b0;
    endtask

    task automatic host_read(logic [31:0] addr, logic [63:0] exp);
        bus.host_req  = 1'b1;
        bus.host_we   = 1'b0;
        bus.host_addr = addr;
        wait_gnt("host_rd_gnt");
        host_q.push_back(exp);
        tick();
        bus.host_req = 1'b0;
    endtask

    task automatic eng_expect(logic [63:0] d1, logic [63:0] d2, logic [63:0] d3);
        eng_exp_t e;
        e.d1 = d1;
        e.d2 = d2;
        e.d3 = d3;
        eng_q.push_back(e);
        eng_issue = 1'b1;
        tick();
        eng_issue = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n             = 1'b0;
        bus.engine_busy   = 1'b0;
        bus.bram_addr_1   = '0;
        bus.bram_addr_2   = '0;
        bus.bram_addr_3   = '0;
        bus.save_wen      = 1'b0;
        bus.save_addr     = '0;
        bus.bram_savedata = '0;
        bus.host_req      = 1'b0;
        bus.host_we       = 1'b0;
        bus.host_addr     = '0;
        bus.host_wdata    = '0;

        // Reset state
        repeat (3) tick();
        @(negedge clk);
        check("rst_data_1", bus.bram_data_1, 64'd0);
        check("rst_data_2", bus.bram_data_2, 64'd0);
        check("rst_data_3", bus.bram_data_3, 64'd0);
        check("rst_host_gnt", 64'(bus.host_gnt), 64'd0);
        check("rst_host_rvalid", 64'(bus.host_rvalid), 64'd0);
        check("rst_host_rdata", bus.host_rdata, 64'd0);
        check("rst_save_count", 64'(save_count), 64'd0);
        check("rst_addr_err", 64'(addr_err), 64'd0);
        tick();
        rst_n = 1'b1;
        tick();

        // Host preload and readback
        host_write(32'h40, W8);
        host_write(32'h48, W9);
        host_read(32'h40, W8);
        host_read(32'h48, W9);

        // Engine reads on all three ports
        bus.bram_addr_1 = 32'h40;
        bus.bram_addr_2 = 32'h44;
        bus.bram_addr_3 = 32'h48;
        bus.engine_busy = 1'b1;
        tick();
        tick();
        eng_expect(W8, W8, W9);

        // Write-first collision on port 2
        bus.save_wen      = 1'b1;
        bus.save_addr     = 32'h80;
        bus.bram_savedata = WAA;
        bus.bram_addr_2   = 32'h80;
        eng_expect(W8, WAA, W9);
        bus.save_wen = 1'b0;
        eng_expect(W8, WAA, W9);

        // Four more saves in ENGINE, then one in DRAIN
        for (int i = 1; i <= 4; i++) begin
            bus.save_wen      = 1'b1;
            bus.save_addr     = 32'h88;
            bus.bram_savedata = 64'(i);
            tick();
        end
        bus.save_wen = 1'b0;
        @(negedge clk);
        check("save_count_engine", 64'(save_count), 64'd5);
        bus.engine_busy = 1'b0;
        tick();
        bus.save_wen      = 1'b1;
        bus.save_addr     = 32'h90;
        bus.bram_savedata = 64'h55;
        tick();
        bus.save_wen = 1'b0;
        @(negedge clk);
        check("save_count_drain", 64'(save_count), 64'd6);

        // A save in IDLE is ignored
        bus.save_wen      = 1'b1;
        bus.save_addr     = 32'h40;
        bus.bram_savedata = 64'hDEAD;
        tick();
        bus.save_wen = 1'b0;
        @(negedge clk);
        check("save_count_idle", 64'(save_count), 64'd6);
        host_read(32'h88, 64'd4);
        host_read(32'h90, 64'h55);
        host_read(32'h40, W8);
        host_read(32'h80, WAA);

        // Engine pre-empts a held host request
        tick();
        tick();
        bus.host_req  = 1'b1;
        bus.host_we   = 1'b0;
        bus.host_addr = 32'h48;
        tick();
        bus.engine_busy = 1'b1;
        @(negedge clk);
        check("prio_gnt_host_busy", 64'(bus.host_gnt), 64'd0);
        tick();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("prio_gnt_engine", 64'(bus.host_gnt), 64'd0);
            tick();
        end
        check("prio_save_count_clr", 64'(save_count), 64'd0);
        bus.engine_busy = 1'b0;
        tick();
        @(negedge clk);
        check("prio_gnt_drain", 64'(bus.host_gnt), 64'd0);
        tick();
        @(negedge clk);
        check("prio_gnt_idle", 64'(bus.host_gnt), 64'd0);
        tick();
        @(negedge clk);
        check("prio_gnt_after", 64'(bus.host_gnt), 64'd1);
        host_q.push_back(W9);
        tick();
        bus.host_req = 1'b0;

        // Out-of-range engine read
        tick();
        tick();
        @(negedge clk);
        check("oor_err_before", 64'(addr_err), 64'd0);
        bus.bram_addr_1 = 32'h40;
        bus.bram_addr_2 = 32'h80;
        bus.bram_addr_3 = 32'h8000;
        bus.engine_busy = 1'b1;
        tick();
        eng_expect(W8, WAA, 64'd0);
        @(negedge clk);
        check("oor_err_set", 64'(addr_err), 64'd1);
        bus.bram_addr_3 = 32'h48;
        eng_expect(W8, WAA, W9);
        bus.engine_busy = 1'b0;
        tick();
        tick();
        bus.bram_addr_1 = '0;
        bus.bram_addr_2 = '0;
        bus.bram_addr_3 = '0;

        // Out-of-range host write is dropped, host read returns zero
        host_write(32'h8040, 64'hBAD);
        host_read(32'h40, W8);
        host_read(32'h8000, 64'd0);
        host_read(32'h48, W9);
        @(negedge clk);
        check("oor_err_sticky", 64'(addr_err), 64'd1);

        // Reset between a granted read and its rvalid
        tick();
        tick();
        bus.host_req  = 1'b1;
        bus.host_we   = 1'b0;
        bus.host_addr = 32'h48;
        wait_gnt("mid_rst_gnt");
        @(posedge clk);
        #1;
        rst_n        = 1'b0;
        bus.host_req = 1'b0;
        @(negedge clk);
        check("mid_rst_rvalid", 64'(bus.host_rvalid), 64'd0);
        check("mid_rst_data_1", bus.bram_data_1, 64'd0);
        check("mid_rst_addr_err", 64'(addr_err), 64'd0);
        tick();
        rst_n = 1'b1;
        tick();
        tick();
        @(negedge clk);
        check("host_q_drained", 64'(host_q.size()), 64'd0);
        check("eng_q_drained", 64'(eng_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
